// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencer.
// It holds the current instruction address and drives the branch-target table
// index straight from the instruction's branch field. The returned target is
// used in the same cycle to compute the next PC, either as an absolute address
// or relative to the current PC. The block also sequences start, stall and
// halt, and counts taken branches.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        single-cycle pulse; begin execution at i_start_addr
//   i_start_addr   initial PC loaded on start
//   i_stall        hold PC this cycle
//   i_halt         decoded halt instruction at current PC
//   i_branch_en    current instruction is a branch
//   i_branch_cond  branch condition true
//   i_branch_rel   1 = PC-relative target, 0 = absolute target
//   i_branch_idx   table index field from the instruction
//   o_lut_addr     index to the target table (combinational copy of i_branch_idx)
//   i_target       16-bit target returned by the table, same cycle
//   o_pc           current instruction address
//   o_valid        PC holds a live instruction (RUN)
//   o_done         program halted
//   o_taken_cnt    taken branches since last start, saturating
module pc_fetch #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [PC_W-1:0]  i_start_addr,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_branch_en,
    input  logic             i_branch_cond,
    input  logic             i_branch_rel,
    input  logic [3:0]       i_branch_idx,
    output logic [3:0]       o_lut_addr,
    input  logic [15:0]      i_target,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_valid,
    output logic             o_done,
    output logic [CNT_W-1:0] o_taken_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_taken_cnt;

    state_t           w_state_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [PC_W-1:0]  w_next_tgt;
    logic             w_taken;

    // The table index is a pure wire so the table lookup and next-PC adder
    // form one combinational path into the PC register.
    assign o_lut_addr = i_branch_idx;

    assign w_taken = i_branch_en & i_branch_cond;

    // Relative: adding only the low PC_W bits of the 16-bit two's complement
    // offset gives the same result modulo 2^PC_W as a full signed add.
    always_comb begin
        w_next_tgt = i_target[PC_W-1:0];
        if (i_branch_rel) begin
            w_next_tgt = r_pc + i_target[PC_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_taken_cnt;
        unique case (r_state)
            IDLE, HALTED: begin
                if (i_start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = i_start_addr;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (i_stall) begin
                    w_state_nxt = RUN;
                end else if (i_halt) begin
                    w_state_nxt = HALTED;
                end else if (w_taken) begin
                    w_pc_nxt = w_next_tgt;
                    if (r_taken_cnt != '1) begin
                        w_cnt_nxt = r_taken_cnt + 1'b1;
                    end
                end else begin
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_taken_cnt <= w_cnt_nxt;
        end
    end

    assign o_pc        = r_pc;
    assign o_valid     = (r_state == RUN);
    assign o_done      = (r_state == HALTED);
    assign o_taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed plus randomized bench for pc_fetch, checked against
// a behavioural reference model of the fetch sequencer.
module tb_pc_fetch;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 8;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             stall;
    logic             halt;
    logic             br_en;
    logic             br_cond;
    logic             br_rel;
    logic [3:0]       br_idx;
    logic [3:0]       lut_addr;
    logic [15:0]      target;
    logic [PC_W-1:0]  pc;
    logic             valid;
    logic             done;
    logic [CNT_W-1:0] taken_cnt;

    logic [15:0] lut [16];

    int total;
    int bad;

    int m_state;
    int m_pc;
    int m_cnt;

    pc_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_start_addr  (start_addr),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_branch_en   (br_en),
        .i_branch_cond (br_cond),
        .i_branch_rel  (br_rel),
        .i_branch_idx  (br_idx),
        .o_lut_addr    (lut_addr),
        .i_target      (target),
        .o_pc          (pc),
        .o_valid       (valid),
        .o_done        (done),
        .o_taken_cnt   (taken_cnt)
    );

    // Behavioural branch-target table, indexed by the instruction field.
    assign target = lut[br_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        start   = 1'b0;
        stall   = 1'b0;
        halt    = 1'b0;
        br_en   = 1'b0;
        br_cond = 1'b0;
        br_rel  = 1'b0;
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_cnt   = 0;
    endtask

    // Next architectural state from the rules, using the inputs held across the edge.
    task automatic model_edge();
        int tgt;
        if (!rst_n) begin
            model_reset();
        end else if (m_state == M_IDLE || m_state == M_HALTED) begin
            if (start) begin
                m_state = M_RUN;
                m_pc    = int'(start_addr);
                m_cnt   = 0;
            end
        end else begin
            if (stall) begin
                // hold everything
            end else if (halt) begin
                m_state = M_HALTED;
            end else if (br_en && br_cond) begin
                tgt = br_rel ? int'($signed(lut[br_idx])) : int'(lut[br_idx]);
                if (br_rel) m_pc = (((m_pc + tgt) % PC_MOD) + PC_MOD) % PC_MOD;
                else        m_pc = tgt % PC_MOD;
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (int'(pc) === m_pc) else begin
            bad++;
            $error("FAIL %s pc got=%0d exp=%0d", tag, pc, m_pc);
        end
        total++;
        assert (valid === (m_state == M_RUN)) else begin
            bad++;
            $error("FAIL %s valid got=%0b exp=%0b", tag, valid, (m_state == M_RUN));
        end
        total++;
        assert (done === (m_state == M_HALTED)) else begin
            bad++;
            $error("FAIL %s done got=%0b exp=%0b", tag, done, (m_state == M_HALTED));
        end
        total++;
        assert (int'(taken_cnt) === m_cnt) else begin
            bad++;
            $error("FAIL %s cnt got=%0d exp=%0d", tag, taken_cnt, m_cnt);
        end
        total++;
        assert (lut_addr === br_idx) else begin
            bad++;
            $error("FAIL %s lut_addr got=%0d exp=%0d", tag, lut_addr, br_idx);
        end
    endtask

    // One clock: edge, update model, compare #1 after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check(tag);
    endtask

    task automatic restart(input int addr);
        clear_inputs();
        if (m_state == M_RUN) begin
            halt = 1'b1;
            step("halt_pre");
            clear_inputs();
        end
        start      = 1'b1;
        start_addr = PC_W'(addr);
        step("start");
        clear_inputs();
    endtask

    task automatic branch(input bit cond, input bit rel, input logic [3:0] idx,
                          input logic [15:0] tv, input string tag);
        br_idx    = idx;
        lut[idx]  = tv;
        br_en     = 1'b1;
        br_cond   = cond;
        br_rel    = rel;
        step(tag);
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) lut[i] = 16'($urandom);
        clear_inputs();
        start_addr = '0;
        br_idx     = 4'd0;
        rst_n      = 1'b0;
        model_reset();
        #3;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // Sequential run from 0
        restart(0);
        for (int i = 0; i < 4; i++) step("seq");

        // Absolute branch at PC=3: not taken then taken
        restart(3);
        branch(1'b0, 1'b0, 4'b0011, 16'd61, "abs_nt");
        restart(3);
        branch(1'b1, 1'b0, 4'b0011, 16'd61, "abs_t");
        branch(1'b1, 1'b0, 4'd9, 16'hFC05, "abs_upper");

        // Relative branches and sequential wrap
        restart(100);
        branch(1'b1, 1'b1, 4'd1, 16'hFFFF, "rel_m1");
        restart(5);
        branch(1'b1, 1'b1, 4'd2, 16'hFFF0, "rel_wrap");
        restart(1023);
        step("seq_wrap");
        branch(1'b1, 1'b0, 4'd4, 16'd20, "abs_20");

        // Stall has priority over halt and branch
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1; halt = 1'b1; br_en = 1'b1; br_cond = 1'b1; br_idx = 4'd5;
            step("stall_prio");
        end
        clear_inputs();
        halt = 1'b1; br_en = 1'b1; br_cond = 1'b1;
        step("halt");
        clear_inputs();
        step("halted_hold");
        start = 1'b1; start_addr = 10'd7;
        step("restart7");
        clear_inputs();

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            br_idx = 4'($urandom);
            br_en = 1'b1; br_cond = 1'b1; br_rel = 1'($urandom);
            step("sat");
        end
        clear_inputs();
        total++;
        assert (int'(taken_cnt) === CNT_MAX) else begin
            bad++;
            $error("FAIL sat_final cnt got=%0d exp=%0d", taken_cnt, CNT_MAX);
        end

        // Asynchronous reset mid-cycle at PC=42
        restart(42);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        start = 1'b1; start_addr = 10'd9;
        step("start_in_rst");
        rst_n = 1'b1;
        start = 1'b0;
        step("post_rst_idle");
        start = 1'b1;
        step("post_rst_start");
        clear_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            start_addr = PC_W'($urandom);
            stall      = ($urandom_range(0, 5) == 0);
            halt       = ($urandom_range(0, 15) == 0);
            br_en      = 1'($urandom);
            br_cond    = 1'($urandom);
            br_rel     = 1'($urandom);
            br_idx     = 4'($urandom);
            if ($urandom_range(0, 3) == 0) lut[br_idx] = 16'($urandom);
            step("rand");
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-sequencing stage that sits directly upstream of the branch-target lookup table. It holds the current instruction address, and drives the 4-bit table index from the decoded branch field. It consumes the 16-bit target returned by the table to compute the next PC, applied as absolute or PC-relative. It also sequences program start, stall, and halt, and reports completion to the testbench/top level.

## Interface
- PC_W, 10, program counter width (instruction memory depth 2^PC_W)
- CNT_W, 8, width of taken-branch counter

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle pulse; begin execution at StartAddr
- StartAddr  in  PC_W  initial PC loaded on Start
- Stall  in  1  hold PC this cycle
- Halt  in  1  decoded halt instruction at current PC
- BranchEn  in  1  current instruction is a branch
- BranchCond  in  1  branch condition true
- BranchRel  in  1  1 = PC-relative target, 0 = absolute target
- BranchIdx  in  4  table index field from the instruction
- LutAddr  out  4  index to the target table; combinational copy of BranchIdx
- Target  in  16  target value returned by the table, same cycle
- PC  out  PC_W  current instruction address
- Valid  out  1  PC holds a live instruction (state RUN)
- Done  out  1  program halted
- TakenCnt  out  CNT_W  number of taken branches since last Start, saturating

## Operation
- States: IDLE, RUN, HALTED. Reset (Reset=0) forces IDLE, PC=0, Done=0, Valid=0, TakenCnt=0, regardless of Clk.
- IDLE:
  - Start=1 -> RUN; PC<=StartAddr; TakenCnt<=0.
  - All other inputs are ignored.
- RUN: next-state priority, highest first:
  - Stall=1 -> PC, state, and TakenCnt hold. Halt and branch are ignored this cycle.
  - Halt=1 -> HALTED; PC holds; Done<=1. A branch in the same cycle is ignored.
  - Taken (BranchEn & BranchCond) -> PC<=NextTgt; TakenCnt<=TakenCnt+1, saturating at 2^CNT_W-1.
  - Otherwise -> PC<=PC+1, modulo 2^PC_W (1023 wraps to 0).
  - Start while in RUN is ignored.
- NextTgt:
  - Absolute: Target[PC_W-1:0]; upper bits are discarded.
  - Relative: (PC + Target) truncated to PC_W bits, with Target treated as 16-bit two's complement. 16'hFFFF means -1.
- HALTED:
  - Done=1, Valid=0, PC frozen at the halt address.
  - Start=1 -> RUN; PC<=StartAddr; Done<=0; TakenCnt<=0.
- BranchEn=1 with BranchCond=0 is a not-taken branch: PC+1, counter unchanged.
- LutAddr=BranchIdx at all times, in every state, including during reset.

## Timing
- All state, PC, Done, and TakenCnt updates occur on the rising Clk edge. Reset assertion is immediate (asynchronous); deassertion is sampled on the next edge.
- Valid is a decode of the state register (RUN), so it is glitch-free and changes only on edges.
- Target must be valid in the same cycle as BranchIdx. LutAddr -> Target -> NextTgt is one combinational path into the PC register.
- Branch latency: the branch target is on PC in the cycle after the taken branch is presented. There is no delay slot and no flush.
- Start -> first Valid instruction: 1 cycle (PC=StartAddr, Valid=1 on the edge after Start).
- Halt -> Done: 1 cycle; Valid falls on the same edge.
- Reset asserted mid-RUN: outputs return to their reset values immediately; Start is required to resume.

## Test plan
- Reset then Start, StartAddr=0, no branches for 5 cycles -> PC=0,1,2,3,4; Valid=1 throughout; Done=0.
- Absolute taken branch at PC=3: BranchIdx=4'b0011, Target=61, BranchRel=0 -> PC=61 next cycle; TakenCnt=1. With BranchCond=0 instead -> PC=4; TakenCnt=0.
- Relative branch at PC=100, Target=16'hFFFF -> PC=99. At PC=5, Target=16'hFFF0 -> PC=1013 (wrap). Sequential wrap from PC=1023 -> PC=0.
- Stall priority: Stall=1 together with Halt=1 and a taken branch for 2 cycles -> PC unchanged, still RUN. Then Halt alone -> Done=1 and Valid=0 next cycle, PC frozen. A later Start with StartAddr=7 -> PC=7, Done=0, TakenCnt=0.
- Counter saturation: 300 consecutive taken branches -> TakenCnt stops at 255.
- Reset asserted asynchronously mid-cycle while PC=42 -> PC=0, Valid=0, Done=0 immediately. Start is ignored until Reset=1; a Start after that -> RUN.
